// File: rtl/nrisc_dbus_periph_if.sv
// Data-memory peripheral bus: master drives address, data and one-cycle strobes;
// the peripheral returns registered read data.
interface nrisc_dbus_periph_if #(
    parameter int N_DData = 8,
    parameter int TAM     = 16
);
    logic [N_DData-1:0] addr;
    logic [TAM-1:0]     wdata;
    logic               write;
    logic               read;
    logic [TAM-1:0]     rdata;

    modport master (output addr, output wdata, output write, output read, input rdata);
    modport slave  (input addr, input wdata, input write, input read, output rdata);
endinterface

// File: rtl/nrisc_dbus_periph.sv
// NRISC data-bus peripheral: GPIO port, 16-bit compare timer with interrupt and an
// outbound show-ahead FIFO with a valid/ready stream.
module nrisc_dbus_periph #(
    parameter int N_DData   = 8,
    parameter int TAM       = 16,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    nrisc_dbus_periph_if.slave  PERIPH_BUS,
    input  logic [TAM-1:0]      PERIPH_gpio_in,
    output logic [TAM-1:0]      PERIPH_gpio_out,
    output logic                PERIPH_irq,
    output logic [TAM-1:0]      PERIPH_fifo_out,
    output logic                PERIPH_fifo_valid,
    input  logic                PERIPH_fifo_ready
);
    localparam int FIFO_DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   DEPTH_CNT = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [FIFO_LOG2:0]   CNT_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_LOG2-1:0] PTR_ONE   = {{(FIFO_LOG2-1){1'b0}}, 1'b1};
    localparam logic [TAM-1:0]       WORD_ONE  = {{(TAM-1){1'b0}}, 1'b1};
    localparam logic [TAM-1:0]       WORD_ZERO = {TAM{1'b0}};

    logic [TAM-1:0]       rdata_r, gpio_out_r, gpio_sync1_r, gpio_sync2_r;
    logic [TAM-1:0]       tmr_cnt_r, tmr_cmp_r;
    logic                 tmr_en_r, tmr_ar_r, tmr_ie_r, match_r, irq_r, ovf_r;
    logic [TAM-1:0]       mem_r [FIFO_DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_LOG2:0]   count_r;

    logic                 mapped_s, empty_s, full_s, pop_s, push_s, push_ok_s, hit_s;
    logic [7:0]           wr_sel_s;
    logic [TAM-1:0]       rd_mux_s, status_s, tmr_cnt_nxt_s;
    logic [FIFO_LOG2:0]   count_nxt_s;

    assign mapped_s  = (PERIPH_BUS.addr[N_DData-1:3] == {(N_DData-3){1'b0}});
    assign empty_s   = (count_r == {(FIFO_LOG2+1){1'b0}});
    assign full_s    = (count_r == DEPTH_CNT);
    assign pop_s     = !empty_s && PERIPH_fifo_ready;
    assign push_s    = wr_sel_s[5];
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign hit_s     = tmr_en_r && (tmr_cnt_r == tmr_cmp_r);

    // Write-enable decode, one bit per register slot.
    always_comb begin
        wr_sel_s = 8'h00;
        if (PERIPH_BUS.write && mapped_s) begin
            wr_sel_s[PERIPH_BUS.addr[2:0]] = 1'b1;
        end else begin
            wr_sel_s = 8'h00;
        end
    end

    // Status word and read-data multiplexer.
    always_comb begin
        status_s                = WORD_ZERO;
        status_s[FIFO_LOG2:0]   = count_r;
        status_s[13]            = ovf_r;
        status_s[14]            = full_s;
        status_s[15]            = empty_s;
        rd_mux_s                = WORD_ZERO;
        if (mapped_s) begin
            case (PERIPH_BUS.addr[2:0])
                3'd0:    rd_mux_s = gpio_out_r;
                3'd1:    rd_mux_s = gpio_sync2_r;
                3'd2:    rd_mux_s = tmr_cnt_r;
                3'd3:    rd_mux_s = tmr_cmp_r;
                3'd4:    rd_mux_s = {match_r, {(TAM-4){1'b0}}, tmr_ie_r, tmr_ar_r, tmr_en_r};
                3'd6:    rd_mux_s = status_s;
                default: rd_mux_s = WORD_ZERO;
            endcase
        end else begin
            rd_mux_s = WORD_ZERO;
        end
    end

    // Next timer count: bus write beats reload, reload beats increment.
    always_comb begin
        tmr_cnt_nxt_s = tmr_cnt_r;
        if (wr_sel_s[2]) begin
            tmr_cnt_nxt_s = PERIPH_BUS.wdata;
        end else if (hit_s && tmr_ar_r) begin
            tmr_cnt_nxt_s = WORD_ZERO;
        end else if (tmr_en_r) begin
            tmr_cnt_nxt_s = tmr_cnt_r + WORD_ONE;
        end else begin
            tmr_cnt_nxt_s = tmr_cnt_r;
        end
    end

    // Next FIFO occupancy.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Bus-visible registers, timer and synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r      <= WORD_ZERO;
            gpio_out_r   <= WORD_ZERO;
            gpio_sync1_r <= WORD_ZERO;
            gpio_sync2_r <= WORD_ZERO;
            tmr_cnt_r    <= WORD_ZERO;
            tmr_cmp_r    <= WORD_ZERO;
            tmr_en_r     <= 1'b0;
            tmr_ar_r     <= 1'b0;
            tmr_ie_r     <= 1'b0;
            match_r      <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            if (PERIPH_BUS.read) rdata_r <= rd_mux_s;
            if (wr_sel_s[0]) gpio_out_r <= PERIPH_BUS.wdata;
            gpio_sync1_r <= PERIPH_gpio_in;
            gpio_sync2_r <= gpio_sync1_r;
            tmr_cnt_r    <= tmr_cnt_nxt_s;
            if (wr_sel_s[3]) tmr_cmp_r <= PERIPH_BUS.wdata;
            if (wr_sel_s[4]) begin
                tmr_en_r <= PERIPH_BUS.wdata[0];
                tmr_ar_r <= PERIPH_BUS.wdata[1];
                tmr_ie_r <= PERIPH_BUS.wdata[2];
            end
            if (hit_s) begin
                match_r <= 1'b1;
            end else if (wr_sel_s[4] && PERIPH_BUS.wdata[TAM-1]) begin
                match_r <= 1'b0;
            end
            irq_r <= match_r && tmr_ie_r;
        end
    end

    // FIFO pointers, count and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_LOG2{1'b0}};
            rd_ptr_r <= {FIFO_LOG2{1'b0}};
            count_r  <= {(FIFO_LOG2+1){1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
            if (push_s && !push_ok_s) begin
                ovf_r <= 1'b1;
            end else if (wr_sel_s[6]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= PERIPH_BUS.wdata;
    end

    assign PERIPH_BUS.rdata  = rdata_r;
    assign PERIPH_gpio_out   = gpio_out_r;
    assign PERIPH_irq        = irq_r;
    assign PERIPH_fifo_out   = mem_r[rd_ptr_r];
    assign PERIPH_fifo_valid = !empty_s;
endmodule

// File: tb/tb_nrisc_dbus_periph.sv
// Directed bench for nrisc_dbus_periph: reset, GPIO, timer, FIFO and decode checks.
module tb_nrisc_dbus_periph;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] gpio_in = 16'h0000;
    logic        fifo_ready = 1'b0;
    logic [15:0] gpio_out, fifo_out;
    logic        irq, fifo_valid;
    logic [15:0] rd;
    logic [15:0] exp_q [8];
    int          n_cmp = 0;
    int          n_mis = 0;

    nrisc_dbus_periph_if #(.N_DData(8), .TAM(16)) bus_if ();

    nrisc_dbus_periph #(.N_DData(8), .TAM(16), .FIFO_LOG2(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .PERIPH_BUS        (bus_if),
        .PERIPH_gpio_in    (gpio_in),
        .PERIPH_gpio_out   (gpio_out),
        .PERIPH_irq        (irq),
        .PERIPH_fifo_out   (fifo_out),
        .PERIPH_fifo_valid (fifo_valid),
        .PERIPH_fifo_ready (fifo_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.write = 1'b1;
        tick();
        bus_if.write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
        bus_if.addr = a;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        d = bus_if.rdata;
    endtask

    initial begin
        bus_if.addr = 8'h00; bus_if.wdata = 16'h0000;
        bus_if.write = 1'b0; bus_if.read = 1'b0;

        // Reset held two cycles while every input toggles.
        bus_if.addr = 8'h05; bus_if.wdata = 16'hFFFF; bus_if.write = 1'b1; bus_if.read = 1'b1;
        fifo_ready = 1'b1; gpio_in = 16'hFFFF;
        tick();
        bus_if.addr = 8'h00; bus_if.wdata = 16'h1234; fifo_ready = 1'b0; gpio_in = 16'h0F0F;
        tick();
        rst = 1'b0; bus_if.write = 1'b0; bus_if.read = 1'b0; gpio_in = 16'h0000;
        check("rst_rdata", bus_if.rdata, 16'h0000);
        check("rst_gpio_out", gpio_out, 16'h0000);
        check("rst_irq", {15'h0000, irq}, 16'h0000);
        check("rst_valid", {15'h0000, fifo_valid}, 16'h0000);
        bus_read(8'h06, rd);
        check("rst_status", rd, 16'h8000);

        // GPIO output and two-flop input path.
        bus_write(8'h00, 16'hA5A5);
        check("gpio_out", gpio_out, 16'hA5A5);
        gpio_in = 16'h1234;
        tick(); tick();
        bus_read(8'h01, rd);
        check("gpio_in", rd, 16'h1234);
        bus_read(8'h00, rd);
        check("gpio_out_rd", rd, 16'hA5A5);

        // Timer with autoreload: count 0,1,2,3,0,1 and match on the wrap.
        bus_write(8'h03, 16'h0003);
        bus_write(8'h04, 16'h0007);
        bus_read(8'h02, rd); check("cnt0", rd, 16'h0000); check("irq_c0", {15'h0000, irq}, 16'h0000);
        bus_read(8'h02, rd); check("cnt1", rd, 16'h0001);
        bus_read(8'h02, rd); check("cnt2", rd, 16'h0002);
        bus_read(8'h02, rd); check("cnt3", rd, 16'h0003); check("irq_at_match", {15'h0000, irq}, 16'h0000);
        bus_read(8'h02, rd); check("cnt_wrap", rd, 16'h0000); check("irq_after", {15'h0000, irq}, 16'h0001);
        bus_read(8'h04, rd); check("ctrl_match", rd, 16'h8007);
        bus_write(8'h04, 16'h8000);
        check("irq_w1c_lag", {15'h0000, irq}, 16'h0001);
        bus_read(8'h02, rd); check("cnt_stop", rd, 16'h0003); check("irq_cleared", {15'h0000, irq}, 16'h0000);
        bus_read(8'h04, rd); check("ctrl_clr", rd, 16'h0000);

        // FIFO fill past depth with the stream stalled.
        for (int i = 1; i <= 9; i++) bus_write(8'h05, 16'(i));
        bus_read(8'h06, rd);
        check("fifo_full_status", rd, 16'h6008);
        check("fifo_head", fifo_out, 16'h0001);
        fifo_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", {15'h0000, fifo_valid}, 16'h0001);
            check("drain_word", fifo_out, 16'(i));
            tick();
        end
        check("drain_done", {15'h0000, fifo_valid}, 16'h0000);
        fifo_ready = 1'b0;
        bus_read(8'h06, rd);
        check("empty_ovf_status", rd, 16'hA000);
        bus_write(8'h06, 16'h0000);
        bus_read(8'h06, rd);
        check("ovf_cleared", rd, 16'h8000);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 8; i++) bus_write(8'h05, 16'h0011 + 16'(i));
        bus_read(8'h06, rd);
        check("refill_status", rd, 16'h4008);
        fifo_ready = 1'b1;
        bus_write(8'h05, 16'h00AA);
        fifo_ready = 1'b0;
        bus_read(8'h06, rd);
        check("pushpop_status", rd, 16'h4008);
        exp_q = '{16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0018, 16'h00AA};
        fifo_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("wrap_word", fifo_out, exp_q[i]);
            tick();
        end
        check("wrap_done", {15'h0000, fifo_valid}, 16'h0000);
        fifo_ready = 1'b0;

        // Read and write to the same address on one edge returns the old value.
        bus_if.addr = 8'h00; bus_if.wdata = 16'h5A5A; bus_if.write = 1'b1; bus_if.read = 1'b1;
        tick();
        bus_if.write = 1'b0; bus_if.read = 1'b0;
        check("rw_old", bus_if.rdata, 16'hA5A5);
        check("rw_new", gpio_out, 16'h5A5A);

        // Unmapped and write-only/reserved slots.
        bus_write(8'h10, 16'hFFFF);
        bus_read(8'h10, rd); check("unmapped_rd", rd, 16'h0000);
        check("unmapped_gpio", gpio_out, 16'h5A5A);
        bus_read(8'h08, rd); check("unmapped_08", rd, 16'h0000);
        bus_read(8'h03, rd); check("cmp_kept", rd, 16'h0003);
        bus_read(8'h05, rd); check("fifo_data_rd", rd, 16'h0000);
        bus_read(8'h07, rd); check("reserved_rd", rd, 16'h0000);
        check("unmapped_no_push", {15'h0000, fifo_valid}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
